// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 32-bit datapath ALU: decodes one MIPS instruction,
// holds ALU operands for a per-op settle time, then hands the result to writeback.
module alu_issue_ctrl #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic [31:0] o_alu_x,
  output logic [31:0] o_alu_y,
  output logic [4:0]  o_alu_shamt,
  output logic [3:0]  o_alu_sel,
  input  logic [31:0] i_alu_res,
  input  logic        i_alu_zf,
  output logic        o_wb_valid,
  input  logic        i_wb_ready,
  output logic [31:0] o_wb_data,
  output logic        o_wb_zf,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_illegal
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [3:0] SEL_IDLE = 4'b1111;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_dest;
  logic        r_in_ready;
  logic [31:0] r_alu_x;
  logic [31:0] r_alu_y;
  logic [4:0]  r_alu_shamt;
  logic [3:0]  r_alu_sel;
  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic        r_wb_zf;
  logic [4:0]  r_wb_rd;
  logic        r_wb_illegal;

  logic        w_legal;
  logic [3:0]  w_sel;
  logic [31:0] w_x;
  logic [31:0] w_y;
  logic [4:0]  w_shamt;
  logic [4:0]  w_dest;
  logic [3:0]  w_len_m1;
  logic [31:0] w_imm_se;
  logic [31:0] w_imm_ze;

  assign w_imm_se = {{16{i_instr[15]}}, i_instr[15:0]};
  assign w_imm_ze = {16'h0000, i_instr[15:0]};

  // Opcode/funct decode into ALU select, operands and destination register
  always_comb begin
    w_legal = 1'b0;
    w_sel   = SEL_IDLE;
    w_x     = i_rs_data;
    w_y     = i_rt_data;
    w_shamt = 5'd0;
    w_dest  = 5'd0;
    case (i_instr[31:26])
      6'h00: begin
        w_dest  = i_instr[15:11];
        w_legal = 1'b1;
        case (i_instr[5:0])
          6'h20, 6'h21: w_sel = 4'b0000;
          6'h22, 6'h23: w_sel = 4'b0001;
          6'h18:        w_sel = 4'b0010;
          6'h1A:        w_sel = 4'b0011;
          6'h24:        w_sel = 4'b0100;
          6'h25:        w_sel = 4'b0101;
          6'h27:        w_sel = 4'b0110;
          6'h00: begin
            w_sel   = 4'b0111;
            w_x     = i_rt_data;
            w_shamt = i_instr[10:6];
          end
          6'h02: begin
            w_sel   = 4'b1000;
            w_x     = i_rt_data;
            w_shamt = i_instr[10:6];
          end
          6'h2A:        w_sel = 4'b1001;
          6'h26:        w_sel = 4'b1010;
          default: begin
            w_legal = 1'b0;
            w_sel   = SEL_IDLE;
          end
        endcase
      end
      6'h08, 6'h09: begin w_legal = 1'b1; w_sel = 4'b0000; w_y = w_imm_se; w_dest = i_instr[20:16]; end
      6'h0A:        begin w_legal = 1'b1; w_sel = 4'b1001; w_y = w_imm_se; w_dest = i_instr[20:16]; end
      6'h0C:        begin w_legal = 1'b1; w_sel = 4'b0100; w_y = w_imm_ze; w_dest = i_instr[20:16]; end
      6'h0D:        begin w_legal = 1'b1; w_sel = 4'b0101; w_y = w_imm_ze; w_dest = i_instr[20:16]; end
      6'h0E:        begin w_legal = 1'b1; w_sel = 4'b1010; w_y = w_imm_ze; w_dest = i_instr[20:16]; end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Settle budget minus one, loaded into the counter on accept
  always_comb begin
    case (w_sel)
      4'b0010: w_len_m1 = 4'(MUL_CYCLES - 1);
      4'b0011: w_len_m1 = 4'(DIV_CYCLES - 1);
      default: w_len_m1 = 4'd0;
    endcase
  end

  // Sequencer state, held ALU operands and writeback registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_dest       <= 5'd0;
      r_in_ready   <= 1'b1;
      r_alu_x      <= 32'd0;
      r_alu_y      <= 32'd0;
      r_alu_shamt  <= 5'd0;
      r_alu_sel    <= SEL_IDLE;
      r_wb_valid   <= 1'b0;
      r_wb_data    <= 32'd0;
      r_wb_zf      <= 1'b0;
      r_wb_rd      <= 5'd0;
      r_wb_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            if (w_legal) begin
              r_alu_x     <= w_x;
              r_alu_y     <= w_y;
              r_alu_shamt <= w_shamt;
              r_alu_sel   <= w_sel;
              r_cnt       <= w_len_m1;
              r_dest      <= w_dest;
              r_state     <= S_EXEC;
            end else begin
              // Undecodable: skip the ALU and report a flagged zero result
              r_wb_data    <= 32'd0;
              r_wb_zf      <= 1'b1;
              r_wb_rd      <= 5'd0;
              r_wb_illegal <= 1'b1;
              r_wb_valid   <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_wb_data    <= i_alu_res;
            r_wb_zf      <= i_alu_zf;
            r_wb_rd      <= r_dest;
            r_wb_illegal <= 1'b0;
            r_wb_valid   <= 1'b1;
            r_alu_x      <= 32'd0;
            r_alu_y      <= 32'd0;
            r_alu_shamt  <= 5'd0;
            r_alu_sel    <= SEL_IDLE;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (i_wb_ready) begin
            r_wb_valid <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_wb_valid <= 1'b0;
          r_alu_sel  <= SEL_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_alu_x      = r_alu_x;
  assign o_alu_y      = r_alu_y;
  assign o_alu_shamt  = r_alu_shamt;
  assign o_alu_sel    = r_alu_sel;
  assign o_wb_valid   = r_wb_valid;
  assign o_wb_data    = r_wb_data;
  assign o_wb_zf      = r_wb_zf;
  assign o_wb_rd      = r_wb_rd;
  assign o_wb_illegal = r_wb_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached to its
// ALU port; expected results come from an independent instruction model.
module tb_alu_issue_ctrl;

  localparam int MUL_C = 3;
  localparam int DIV_C = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_instr;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic [31:0] o_alu_x;
  logic [31:0] o_alu_y;
  logic [4:0]  o_alu_shamt;
  logic [3:0]  o_alu_sel;
  logic [31:0] w_alu_res;
  logic        w_alu_zf;
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic [31:0] o_wb_data;
  logic        o_wb_zf;
  logic [4:0]  o_wb_rd;
  logic        o_wb_illegal;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        zf;
    logic [4:0]  rd;
    logic        ill;
    int          lat;
    logic [3:0]  sel;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sh;
  } exp_t;

  exp_t sb_q[$];

  alu_issue_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_instr(i_instr), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .o_alu_x(o_alu_x), .o_alu_y(o_alu_y), .o_alu_shamt(o_alu_shamt), .o_alu_sel(o_alu_sel),
    .i_alu_res(w_alu_res), .i_alu_zf(w_alu_zf),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_data(o_wb_data),
    .o_wb_zf(o_wb_zf), .o_wb_rd(o_wb_rd), .o_wb_illegal(o_wb_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural datapath ALU
  always_comb begin
    case (o_alu_sel)
      4'b0000: w_alu_res = o_alu_x + o_alu_y;
      4'b0001: w_alu_res = o_alu_x - o_alu_y;
      4'b0010: w_alu_res = o_alu_x * o_alu_y;
      4'b0011: w_alu_res = (o_alu_y == 32'd0) ? 32'd0 : o_alu_x / o_alu_y;
      4'b0100: w_alu_res = o_alu_x & o_alu_y;
      4'b0101: w_alu_res = o_alu_x | o_alu_y;
      4'b0110: w_alu_res = ~(o_alu_x | o_alu_y);
      4'b0111: w_alu_res = o_alu_y << o_alu_shamt;
      4'b1000: w_alu_res = o_alu_y >> o_alu_shamt;
      4'b1001: w_alu_res = ($signed(o_alu_x) < $signed(o_alu_y)) ? 32'd1 : 32'd0;
      4'b1010: w_alu_res = o_alu_x ^ o_alu_y;
      default: w_alu_res = 32'd0;
    endcase
    w_alu_zf = (w_alu_res == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Instruction-level model of what writeback should see
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [31:0] se;
    logic [31:0] ze;
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    e.ill = 1'b0; e.lat = 1; e.x = rs; e.y = rt; e.sh = 5'd0; e.data = 32'd0; e.sel = 4'hF;
    e.rd = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20, 6'h21: begin e.sel = 4'h0; e.data = rs + rt; end
        6'h22, 6'h23: begin e.sel = 4'h1; e.data = rs - rt; end
        6'h18: begin e.sel = 4'h2; e.data = rs * rt; e.lat = MUL_C; end
        6'h1A: begin e.sel = 4'h3; e.data = (rt == 32'd0) ? 32'd0 : rs / rt; e.lat = DIV_C; end
        6'h24: begin e.sel = 4'h4; e.data = rs & rt; end
        6'h25: begin e.sel = 4'h5; e.data = rs | rt; end
        6'h27: begin e.sel = 4'h6; e.data = ~(rs | rt); end
        6'h00: begin e.sel = 4'h7; e.x = rt; e.sh = ins[10:6]; e.data = rt << ins[10:6]; end
        6'h02: begin e.sel = 4'h8; e.x = rt; e.sh = ins[10:6]; e.data = rt >> ins[10:6]; end
        6'h2A: begin e.sel = 4'h9; e.data = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
        6'h26: begin e.sel = 4'hA; e.data = rs ^ rt; end
        default: e.ill = 1'b1;
      endcase
      6'h08, 6'h09: begin e.sel = 4'h0; e.y = se; e.data = rs + se; end
      6'h0A: begin e.sel = 4'h9; e.y = se; e.data = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0C: begin e.sel = 4'h4; e.y = ze; e.data = rs & ze; end
      6'h0D: begin e.sel = 4'h5; e.y = ze; e.data = rs | ze; end
      6'h0E: begin e.sel = 4'hA; e.y = ze; e.data = rs ^ ze; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.data = 32'd0; e.rd = 5'd0; e.lat = 0; e.sel = 4'hF; e.x = 32'd0; e.y = 32'd0; e.sh = 5'd0;
    end
    e.zf = (e.data == 32'd0);
    return e;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, {31'd0, o_in_ready}, 32'd1);
    check({tag, "_wb_valid"}, {31'd0, o_wb_valid}, 32'd0);
    check({tag, "_wb_data"}, o_wb_data, 32'd0);
    check({tag, "_wb_zf"}, {31'd0, o_wb_zf}, 32'd0);
    check({tag, "_wb_rd"}, {27'd0, o_wb_rd}, 32'd0);
    check({tag, "_wb_ill"}, {31'd0, o_wb_illegal}, 32'd0);
    check({tag, "_alu_x"}, o_alu_x, 32'd0);
    check({tag, "_alu_y"}, o_alu_y, 32'd0);
    check({tag, "_alu_sh"}, {27'd0, o_alu_shamt}, 32'd0);
    check({tag, "_alu_sel"}, {28'd0, o_alu_sel}, 32'hF);
  endtask

  // Drive one instruction, then compare the popped expectation at writeback
  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input int hold);
    exp_t e;
    exp_t g;
    int n;
    e = model(ins, rs, rt);
    sb_q.push_back(e);
    n = 0;
    while (!o_in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_in_ready"}, {31'd0, o_in_ready}, 32'd1);
    i_instr = ins; i_rs_data = rs; i_rt_data = rt; i_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_instr = $urandom; i_rs_data = $urandom; i_rt_data = $urandom;
    check({tag, "_sel"}, {28'd0, o_alu_sel}, {28'd0, e.sel});
    check({tag, "_x"}, o_alu_x, e.x);
    check({tag, "_y"}, o_alu_y, e.y);
    check({tag, "_sh"}, {27'd0, o_alu_shamt}, {27'd0, e.sh});
    n = 0;
    while (!o_wb_valid && n < 40) begin
      check({tag, "_busy_rdy"}, {31'd0, o_in_ready}, 32'd0);
      check({tag, "_hold_sel"}, {28'd0, o_alu_sel}, {28'd0, e.sel});
      i_in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(e.lat));
    check({tag, "_sel_rel"}, {28'd0, o_alu_sel}, 32'hF);
    g = sb_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      check({tag, "_valid"}, {31'd0, o_wb_valid}, 32'd1);
      check({tag, "_data"}, o_wb_data, g.data);
      check({tag, "_zf"}, {31'd0, o_wb_zf}, {31'd0, g.zf});
      check({tag, "_rd"}, {27'd0, o_wb_rd}, {27'd0, g.rd});
      check({tag, "_ill"}, {31'd0, o_wb_illegal}, {31'd0, g.ill});
      check({tag, "_done_rdy"}, {31'd0, o_in_ready}, 32'd0);
      if (h < hold) @(negedge clk);
    end
    i_in_valid = 1'b0;
    i_wb_ready = 1'b1;
    @(negedge clk);
    i_wb_ready = 1'b0;
    check({tag, "_wb_drop"}, {31'd0, o_wb_valid}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, o_in_ready}, 32'd1);
  endtask

  initial begin
    i_reset = 1'b1; i_in_valid = 1'b0; i_wb_ready = 1'b0;
    i_instr = 32'd0; i_rs_data = 32'd0; i_rt_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    i_reset = 1'b0;
    @(negedge clk);

    run_op("addi",  {6'h08, 5'd3, 5'd5, 16'hFFFF}, 32'h10, 32'h0, 0);
    run_op("sub",   {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 32'h1234, 32'h1234, 0);
    run_op("andi",  {6'h0C, 5'd1, 5'd4, 16'h8000}, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("div",   {6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h1A}, 32'd100, 32'd7, 0);
    run_op("sll",   {6'h00, 5'd0, 5'd1, 5'd2, 5'd4, 6'h00}, 32'hDEAD_BEEF, 32'h1, 3);
    run_op("ill",   32'hFC00_0000, 32'h5555_5555, 32'hAAAA_AAAA, 1);
    run_op("illfn", {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h3F}, 32'h1, 32'h2, 0);
    run_op("mul",   {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h18}, 32'd1234, 32'd5678, 0);
    run_op("srl",   {6'h00, 5'd0, 5'd11, 5'd12, 5'd31, 6'h02}, 32'h0, 32'h8000_0000, 0);
    run_op("slt",   {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h2A}, 32'hFFFF_FFFE, 32'h1, 0);
    run_op("slti",  {6'h0A, 5'd1, 5'd13, 16'h8000}, 32'h0, 32'h0, 0);
    run_op("nor",   {6'h00, 5'd1, 5'd2, 5'd14, 5'd0, 6'h27}, 32'h0F0F_0000, 32'h0000_00F0, 0);
    run_op("xori",  {6'h0E, 5'd1, 5'd15, 16'hFFFF}, 32'h1234_5678, 32'h0, 0);
    run_op("div0",  {6'h00, 5'd1, 5'd2, 5'd16, 5'd0, 6'h1A}, 32'd9, 32'd0, 0);

    // Reset in the second EXEC cycle of a multiply drops the pending result
    i_instr = {6'h00, 5'd1, 5'd2, 5'd17, 5'd0, 6'h18}; i_rs_data = 32'd3; i_rt_data = 32'd4;
    i_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_in_valid = 1'b0;
    check("mulr_sel", {28'd0, o_alu_sel}, 32'h2);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check_reset_state("mulr");
    i_reset = 1'b0;
    @(negedge clk);
    check("mulr_quiet", {31'd0, o_wb_valid}, 32'd0);
    run_op("or",    {6'h00, 5'd1, 5'd2, 5'd18, 5'd0, 6'h25}, 32'hF0, 32'h0F, 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Front-end sequencer that drives the 32-bit datapath ALU. It accepts one decoded-register-read instruction at a time over a valid/ready handshake and translates MIPS opcode/funct into the ALU's 4-bit select code and operand set. It holds the operands stable for a per-operation number of cycles, with multi-cycle slots for the long combinational MUL/DIV paths. It then registers the ALU result and zero flag and presents them to writeback over a second valid/ready handshake.

Parameters:
MUL_CYCLES, 2, ALU settle cycles for multiply; legal range 1..15
DIV_CYCLES, 4, ALU settle cycles for divide; legal range 1..15

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  instruction + operands valid
in_ready  out  1  block can accept
instr  in  32  MIPS instruction word
rs_data  in  32  register rs value
rt_data  in  32  register rt value
alu_x  out  32  to ALU x32bit
alu_y  out  32  to ALU y32bit
alu_shamt  out  5  to ALU shiftAmount
alu_sel  out  4  to ALU sel
alu_res  in  32  from ALU res32bit
alu_zf  in  1  from ALU zf
wb_valid  out  1  result valid
wb_ready  in  1  writeback accepts
wb_data  out  32  registered result
wb_zf  out  1  registered zero flag
wb_rd  out  5  destination register
wb_illegal  out  1  instruction not decodable, data forced 0

Behaviour:
- States: IDLE, EXEC, DONE. State is a one-hot or binary encoding; only the transitions below are legal.
- Reset values: state=IDLE, in_ready=1, wb_valid=0, wb_data=0, wb_zf=0, wb_rd=0, wb_illegal=0, alu_x=0, alu_y=0, alu_shamt=0, alu_sel=4'b1111, cycle counter=0.
- Reset has priority over every other event, including mid-EXEC and in DONE with wb_valid high. The pending result is discarded.
- in_ready=1 only in IDLE. An instruction is accepted when in_valid&in_ready at a clock edge. instr, rs_data and rt_data are latched on that edge.
- Decode, R-type (opcode 0x00), dest=instr[15:11]:
  - add/addu 0x20/0x21 -> 0000
  - sub/subu 0x22/0x23 -> 0001
  - mul 0x18 -> 0010
  - div 0x1A -> 0011
  - and 0x24 -> 0100
  - or 0x25 -> 0101
  - nor 0x27 -> 0110
  - sll 0x00 -> 0111
  - srl 0x02 -> 1000
  - slt 0x2A -> 1001
  - xor 0x26 -> 1010
- R-type operands: x=rs_data, y=rt_data. For sll/srl: x=y=rt_data and shamt=instr[10:6]. For all other ops shamt=0.
- Decode, I-type, dest=instr[20:16], x=rs_data, shamt=0:
  - addi/addiu 0x08/0x09 -> 0000, y=sign-extended imm16
  - slti 0x0A -> 1001, y=sign-extended imm16
  - andi 0x0C -> 0100, y=zero-extended imm16
  - ori 0x0D -> 0101, y=zero-extended imm16
  - xori 0x0E -> 1010, y=zero-extended imm16
- Any other opcode/funct is illegal.
- IDLE -> EXEC on accept (legal instruction):
  - alu_x/y/shamt/sel are registered on the accept edge and held constant through EXEC.
  - Counter loads L-1, where L=MUL_CYCLES for 0010, DIV_CYCLES for 0011, and 1 otherwise.
- EXEC:
  - Counter decrements each cycle while nonzero.
  - On the edge where counter==0: wb_data<=alu_res, wb_zf<=alu_zf, wb_rd<=dest, wb_illegal<=0, wb_valid<=1, state->DONE.
  - Alu_* outputs return to reset values on the same edge.
- Latency: accept at edge N -> wb_valid high after edge N+L. Example: add gives wb_valid in the cycle following edge N+1.
- IDLE -> DONE directly on accept of an illegal instruction: wb_data=0, wb_zf=1, wb_rd=0, wb_illegal=1. The ALU is not driven (sel stays 1111).
- DONE: wb_* outputs are held stable while wb_valid&~wb_ready. On wb_valid&wb_ready: wb_valid<=0, state->IDLE.
- A new accept is possible on the cycle after the wb handshake edge, so back-to-back throughput is 1 instruction per L+2 cycles.
- wb_rd=0 is passed unchanged; the register file ignores writes to r0.
- in_valid may toggle freely outside IDLE; the block ignores it.
- DIV by zero: whatever the ALU returns is captured unchanged; there is no trap.

Test Plan:
- Reset, then addi $5,$3,-1 with rs_data=0x00000010 -> alu_sel=0000, alu_y=0xFFFFFFFF; wb_valid 2 edges after accept with wb_data=0x0000000F, wb_rd=5, wb_zf=0, wb_illegal=0.
- sub with rs=rt=0x1234 -> wb_data=0, wb_zf=1. Then andi with imm=0x8000 -> alu_y=0x00008000 (zero-extended).
- div with DIV_CYCLES=4, rs=100, rt=7 -> alu_sel=0011 held 4 cycles; wb_valid exactly 5 edges after accept with wb_data=14; in_ready=0 throughout.
- sll rd=2, rt=0x1, shamt=4 -> alu_shamt=4, alu_sel=0111, wb_data=0x10. Hold wb_ready=0 for 3 cycles: wb outputs stable, in_ready=0. Raise wb_ready: in_ready=1 on the next cycle.
- instr=0xFC000000 (illegal opcode) -> wb_valid 1 edge after accept, wb_illegal=1, wb_data=0, alu_sel stays 1111.
- Assert reset during cycle 2 of a mul with MUL_CYCLES=3 -> next cycle all outputs at reset values and in_ready=1. A following or (rs=0xF0, rt=0x0F) completes normally with wb_data=0xFF.
